// File: rtl/cipher_pkg.sv
// Shared types and key schedule for the cipher frame sequencer and its cipher cores.
package cipher_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } cipher_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PROC  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Fixed key byte for position j of a SEC_LEN-byte repeating key.
    function automatic byte_t key_byte(input int unsigned j);
        return 8'hA5 ^ 8'(j * 32'd59);
    endfunction

endpackage

// File: rtl/cipher_frame_sequencer_cores.sv
// Combinational array cipher cores: per-byte key xor, rotate and position offset.
module encryptor
    import cipher_pkg::*;
#(
    parameter int unsigned MSG_LEN = 20,
    parameter int unsigned SEC_LEN = 7
) (
    input  byte_t plain_i  [MSG_LEN],
    output byte_t cipher_o [MSG_LEN]
);

    for (genvar i = 0; i < MSG_LEN; i++) begin : g_byte
        byte_t mixed;
        assign mixed       = plain_i[i] ^ key_byte(i % SEC_LEN);
        assign cipher_o[i] = {mixed[6:0], mixed[7]} + 8'(i);
    end

endmodule

// Exact inverse of encryptor for the same MSG_LEN/SEC_LEN.
module decryptor
    import cipher_pkg::*;
#(
    parameter int unsigned MSG_LEN = 20,
    parameter int unsigned SEC_LEN = 7
) (
    input  byte_t cipher_i [MSG_LEN],
    output byte_t plain_o  [MSG_LEN]
);

    for (genvar i = 0; i < MSG_LEN; i++) begin : g_byte
        byte_t unoff;
        assign unoff      = cipher_i[i] - 8'(i);
        assign plain_o[i] = {unoff[0], unoff[7:1]} ^ key_byte(i % SEC_LEN);
    end

endmodule

// File: rtl/cipher_frame_sequencer.sv
// Byte-serial front-end: gathers a frame, runs it through the selected cipher core once,
// then streams the processed bytes out. Single frame buffer, no overlap between frames.
module cipher_frame_sequencer
    import cipher_pkg::*;
#(
    parameter int unsigned MSG_LEN = 20,
    parameter int unsigned SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_i,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned CNT_W = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MSG_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    cipher_mode_e     mode_q, mode_d;
    byte_t            ibuf_q [MSG_LEN];
    byte_t            ibuf_d [MSG_LEN];
    byte_t            obuf_q [MSG_LEN];
    byte_t            obuf_d [MSG_LEN];
    byte_t            pad_buf [MSG_LEN];
    byte_t            enc_out [MSG_LEN];
    byte_t            dec_out [MSG_LEN];

    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    byte_t      out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       busy_q, busy_d;
    logic       overflow_q, overflow_d;
    logic       in_acc, out_acc;

    assign in_acc  = in_valid && in_ready_q;
    assign out_acc = out_valid_q && out_ready;

    // Stale bytes from an earlier, longer frame must not reach the cores.
    always_comb begin
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            pad_buf[i] = (CNT_W'(i) < cnt_q) ? ibuf_q[i] : 8'h00;
        end
    end

    encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_encryptor (
        .plain_i  (pad_buf),
        .cipher_o (enc_out)
    );

    decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_decryptor (
        .cipher_i (pad_buf),
        .plain_o  (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rd_q        <= '0;
            mode_q      <= MODE_ENC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                ibuf_q[i] <= '0;
                obuf_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            ibuf_q      <= ibuf_d;
            obuf_q      <= obuf_d;
        end
    end

    // Next state plus buffer/counter updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        mode_d     = mode_q;
        ibuf_d     = ibuf_q;
        obuf_d     = obuf_q;
        overflow_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    mode_d    = cipher_mode_e'(mode_i);
                    ibuf_d[0] = in_data;
                    cnt_d     = CNT_ONE;
                    state_d   = in_last ? PROC : LOAD;
                end
            end
            LOAD: begin
                if (in_acc) begin
                    ibuf_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + CNT_ONE;
                    if (in_last) begin
                        state_d = PROC;
                    end else if (cnt_d == CNT_MAX) begin
                        state_d    = PROC;
                        overflow_d = 1'b1;
                    end
                end
            end
            PROC: begin
                if (mode_q == MODE_DEC) begin
                    obuf_d = dec_out;
                end else begin
                    obuf_d = enc_out;
                end
                rd_d    = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_acc) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rd_d    = '0;
                    end else begin
                        rd_d = rd_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DRAIN);
        out_data_d  = '0;
        out_last_d  = 1'b0;
        if (state_d == DRAIN) begin
            out_data_d = obuf_d[rd_d];
            out_last_d = (rd_d == (cnt_d - CNT_ONE));
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cipher_frame_sequencer.sv
// Directed bench for cipher_frame_sequencer: framing, latency, overflow, back-pressure, reset.
module tb_cipher_frame_sequencer;
    import cipher_pkg::*;

    localparam int unsigned MSG_LEN = 20;
    localparam int unsigned SEC_LEN = 7;
    typedef byte_t frame_t [MSG_LEN];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_i = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned ov_cnt = 0;
    byte_t       rx [$];
    bit          rxl [$];
    frame_t      ref_in;
    frame_t      ref_out;

    always #5 clk = ~clk;

    cipher_frame_sequencer #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_i    (mode_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_ref_enc (
        .plain_i  (ref_in),
        .cipher_o (ref_out)
    );

    always @(negedge clk) if (overflow) ov_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_encrypt(input frame_t p, output frame_t c);
        ref_in = p;
        #1;
        c = ref_out;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input byte_t d, input logic last, input logic m);
        int unsigned guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode_i   = m;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int unsigned n, input logic m_first,
                              input logic m_rest, input bit last_on_n);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(f[i], last_on_n && (i == n - 1), (i == 0) ? m_first : m_rest);
            check($sformatf("busy_in_b%0d", i), 32'(busy), 32'd1);
        end
    endtask

    task automatic drain(input bit stall);
        int unsigned cyc = 0;
        bit done = 1'b0;
        bit was_stalled = 1'b0;
        bit rdy_in_drain = 1'b0;
        bit busy_low = 1'b0;
        byte_t held = 8'h00;
        rx.delete();
        rxl.delete();
        while (!done && cyc < 400) begin
            if (was_stalled) check("stall_stable", 32'(out_data), 32'(held));
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            was_stalled = 1'b0;
            if (out_valid) begin
                if (in_ready) rdy_in_drain = 1'b1;
                if (!busy) busy_low = 1'b1;
                if (out_ready) begin
                    rx.push_back(out_data);
                    rxl.push_back(out_last);
                    if (out_last) done = 1'b1;
                end else begin
                    held = out_data;
                    was_stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_done", 32'(done), 32'd1);
        check("drain_in_ready_low", 32'(rdy_in_drain), 32'd0);
        check("drain_busy_high", 32'(busy_low), 32'd0);
    endtask

    task automatic check_frame(input string tag, input frame_t exp, input int unsigned n);
        check({tag, "_len"}, 32'(rx.size()), n);
        for (int unsigned i = 0; i < n && i < rx.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(rx[i]), 32'(exp[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(rxl[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s1 = "AABBCCDDEEAABBCCDDEE";
        string s3 = "HELLO";
        frame_t plain, f, exp, enc1;
        int unsigned ov0;
        int unsigned g;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full 20-byte encrypt frame, in_last on byte 20
        for (int unsigned i = 0; i < MSG_LEN; i++) plain[i] = byte_t'(s1[i]);
        ref_encrypt(plain, exp);
        @(negedge clk);
        ov0 = ov_cnt;
        send_frame(plain, 20, 1'b0, 1'b0, 1'b1);
        check("t1_in_ready_proc", 32'(in_ready), 32'd0);
        drain(1'b0);
        check_frame("t1", exp, 20);
        check("t1_no_overflow", ov_cnt - ov0, 32'd0);
        for (int unsigned i = 0; i < MSG_LEN; i++) enc1[i] = (i < rx.size()) ? rx[i] : 8'h00;

        // 2: decrypt round trip; mode_i flips after the first byte and must be ignored
        send_frame(enc1, 20, 1'b1, 1'b0, 1'b1);
        drain(1'b0);
        check_frame("t2", plain, 20);

        // 3: short frame, padding and latency
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = (i < 5) ? byte_t'(s3[i]) : 8'h00;
        ref_encrypt(f, exp);
        @(negedge clk);
        send_frame(f, 5, 1'b0, 1'b0, 1'b1);
        check("t3_valid_in_proc", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t3_valid_after_proc", 32'(out_valid), 32'd1);
        check("t3_first_byte", 32'(out_data), 32'(exp[0]));
        drain(1'b0);
        check_frame("t3", exp, 5);

        // 4: 22 bytes without in_last at byte 20
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = 8'(32'h10 + i);
        ref_encrypt(f, exp);
        @(negedge clk);
        ov0 = ov_cnt;
        send_frame(f, 20, 1'b0, 1'b0, 1'b0);
        check("t4_overflow_pulse", 32'(overflow), 32'd1);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t4_overflow_clear", 32'(overflow), 32'd0);
        drain(1'b0);
        check_frame("t4a", exp, 20);
        check("t4_overflow_once", ov_cnt - ov0, 32'd1);
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = (i < 2) ? 8'(32'h24 + i) : 8'h00;
        ref_encrypt(f, exp);
        @(negedge clk);
        send_frame(f, 2, 1'b0, 1'b0, 1'b1);
        drain(1'b0);
        check_frame("t4b", exp, 2);

        // 5: random back-pressure during DRAIN
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = (i < 12) ? 8'(32'h30 + 3 * i) : 8'h00;
        ref_encrypt(f, exp);
        @(negedge clk);
        send_frame(f, 12, 1'b0, 1'b0, 1'b1);
        drain(1'b1);
        check_frame("t5", exp, 12);

        // 6a: reset in LOAD with 7 bytes held
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = 8'h55;
        send_frame(f, 7, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6a_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = (i < 3) ? 8'(32'h61 + i) : 8'h00;
        ref_encrypt(f, exp);
        @(negedge clk);
        send_frame(f, 3, 1'b0, 1'b0, 1'b1);
        drain(1'b0);
        check_frame("t6a", exp, 3);

        // 6b: reset in DRAIN after three handshakes
        for (int unsigned i = 0; i < MSG_LEN; i++) f[i] = (i < 10) ? 8'(32'h70 + i) : 8'h00;
        ref_encrypt(f, exp);
        @(negedge clk);
        send_frame(f, 10, 1'b0, 1'b0, 1'b1);
        g = 0;
        while (!out_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        check("t6b_mid_valid", 32'(out_valid), 32'd1);
        check("t6b_mid_data", 32'(out_data), 32'(exp[3]));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6b_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < MSG_LEN; i++) plain[i] = (i < 4) ? 8'(i + 1) : 8'h00;
        ref_encrypt(plain, f);
        @(negedge clk);
        send_frame(f, 4, 1'b1, 1'b1, 1'b1);
        drain(1'b0);
        check_frame("t6b", plain, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
